// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: expands one parallel command into protocol bytes and serializes them as UART frames.
module uart_cmd_sequencer #(
  parameter int BIT_CNT_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_TYPE,
  input  logic [3:0]               CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]    CMD_DATA0,
  input  logic [DATA_WIDTH-1:0]    CMD_DATA1,
  input  logic [3:0]               CMD_FUNC,
  input  logic [BIT_CNT_WIDTH-1:0] BIT_CYCLES,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic [3:0]               GAP_BITS,
  output logic                     SER_OUT,
  output logic                     BUSY,
  output logic                     FRAME_DONE,
  output logic                     CMD_DONE
);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  state_t r_state, w_nstate;
  logic [BIT_CNT_WIDTH-1:0] r_bcnt, w_nbcnt, r_bmax;
  logic [IW-1:0] r_bidx, w_nbidx;
  logic [1:0] r_fidx, w_nfidx, r_nfr, w_nfr;
  logic [3:0] r_gidx, w_ngidx, r_gap;
  logic r_pen, r_ptyp;
  logic [DATA_WIDTH-1:0] r_bytes [4];
  logic [DATA_WIDTH-1:0] w_bytes [4];
  logic [DATA_WIDTH-1:0] w_byte;
  logic w_accept, w_bend, w_blast, w_ser, w_fdone;
  always_comb begin
    w_accept = r_state == IDLE && CMD_VALID;
    w_bend   = r_bcnt == r_bmax;
    w_blast  = r_bidx == IW'(DATA_WIDTH - 1);
    w_byte   = r_bytes[r_fidx];
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nstate = START;
      START:   if (w_bend) w_nstate = DATA;
      DATA:    if (w_bend && w_blast) w_nstate = r_pen ? PARITY : STOP;
      PARITY:  if (w_bend) w_nstate = STOP;
      STOP:    if (w_bend) w_nstate = r_fidx == r_nfr ? IDLE : (r_gap != 4'd0 ? GAP : START);
      GAP:     if (w_bend && r_gidx == r_gap - 4'd1) w_nstate = START;
      default: w_nstate = IDLE;
    endcase
    w_nbcnt = (r_state == IDLE || w_bend) ? '0 : r_bcnt + 1'b1;
    w_nbidx = (r_state != DATA || (w_bend && w_blast)) ? '0 : (w_bend ? r_bidx + 1'b1 : r_bidx);
    w_nfidx = r_state == IDLE ? 2'd0 : ((r_state == STOP && w_bend) ? r_fidx + 1'b1 : r_fidx);
    w_ngidx = r_state != GAP ? 4'd0 : (w_bend ? r_gidx + 1'b1 : r_gidx);
    // Output register is loaded from the next state so the line lines up with the state it reflects
    w_ser   = w_nstate == START ? 1'b0 :
              w_nstate == DATA ? w_byte[w_nbidx] :
              w_nstate == PARITY ? (^w_byte) ^ r_ptyp : 1'b1;
    w_fdone = w_nstate == STOP && w_nbcnt == r_bmax;
    w_bytes[0] = CMD_TYPE == 2'd0 ? DATA_WIDTH'(8'hAA) :
                 CMD_TYPE == 2'd1 ? DATA_WIDTH'(8'hBB) :
                 CMD_TYPE == 2'd2 ? DATA_WIDTH'(8'hCC) : DATA_WIDTH'(8'hDD);
    w_bytes[1] = CMD_TYPE[1] ? (CMD_TYPE[0] ? DATA_WIDTH'(CMD_FUNC) : CMD_DATA0) : DATA_WIDTH'(CMD_ADDR);
    w_bytes[2] = CMD_TYPE == 2'd2 ? CMD_DATA1 : CMD_DATA0;
    w_bytes[3] = DATA_WIDTH'(CMD_FUNC);
    w_nfr      = CMD_TYPE == 2'd0 ? 2'd2 : CMD_TYPE == 2'd2 ? 2'd3 : 2'd1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_bcnt     <= '0;
      r_bidx     <= '0;
      r_fidx     <= 2'd0;
      r_gidx     <= 4'd0;
      r_bmax     <= '0;
      r_nfr      <= 2'd0;
      r_gap      <= 4'd0;
      r_pen      <= 1'b0;
      r_ptyp     <= 1'b0;
      SER_OUT    <= 1'b1;
      CMD_READY  <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      CMD_DONE   <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_bcnt     <= w_nbcnt;
      r_bidx     <= w_nbidx;
      r_fidx     <= w_nfidx;
      r_gidx     <= w_ngidx;
      SER_OUT    <= w_ser;
      CMD_READY  <= w_nstate == IDLE;
      BUSY       <= w_nstate != IDLE;
      FRAME_DONE <= w_fdone;
      CMD_DONE   <= w_fdone && w_nfidx == r_nfr;
      if (w_accept) begin
        r_bmax <= BIT_CYCLES == '0 ? '0 : BIT_CYCLES - 1'b1;
        r_nfr  <= w_nfr;
        r_gap  <= GAP_BITS;
        r_pen  <= PAR_EN;
        r_ptyp <= PAR_TYP;
        for (int k = 0; k < 4; k++) r_bytes[k] <= w_bytes[k];
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed scenario tests comparing the serial line cycle by cycle with a frame model.
module tb_uart_cmd_sequencer;
  logic CLK = 0, RST = 1, CMD_VALID = 0, PAR_EN = 0, PAR_TYP = 0;
  logic CMD_READY, SER_OUT, BUSY, FRAME_DONE, CMD_DONE;
  logic [1:0] CMD_TYPE = 0;
  logic [3:0] CMD_ADDR = 0, CMD_FUNC = 0, GAP_BITS = 0;
  logic [7:0] CMD_DATA0 = 0, CMD_DATA1 = 0;
  logic [15:0] BIT_CYCLES = 0;
  int tests = 0, fails = 0, exp_len;
  logic exp_ser [4096];
  logic exp_fd [4096];
  logic bs, bf, bc, bb;

  uart_cmd_sequencer dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA0(CMD_DATA0), .CMD_DATA1(CMD_DATA1), .CMD_FUNC(CMD_FUNC),
    .BIT_CYCLES(BIT_CYCLES), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .GAP_BITS(GAP_BITS),
    .SER_OUT(SER_OUT), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .CMD_DONE(CMD_DONE)
  );

  always #5 CLK = ~CLK;

  // Expected line waveform: bytes packed low byte first, pb holds the hand-computed parity bit per frame
  function automatic void build(input int nf, input logic [31:0] bytes, input logic pe,
                                input logic [3:0] pb, input int b, input int g);
    logic [10:0] fr;
    int nb;
    exp_len = 0;
    for (int f = 0; f < nf; f++) begin
      fr = pe ? {1'b1, pb[f], bytes[8*f +: 8], 1'b0} : {2'b11, bytes[8*f +: 8], 1'b0};
      nb = pe ? 11 : 10;
      for (int k = 0; k < nb; k++)
        for (int c = 0; c < b; c++) begin
          exp_ser[exp_len] = fr[k];
          exp_fd[exp_len] = (k == nb - 1) && (c == b - 1);
          exp_len++;
        end
      if (f < nf - 1)
        for (int c = 0; c < g * b; c++) begin
          exp_ser[exp_len] = 1'b1;
          exp_fd[exp_len] = 1'b0;
          exp_len++;
        end
    end
  endfunction

  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [3:0] fn, input logic [15:0] bcy, input logic pe, input logic pt,
                       input logic [3:0] g);
    CMD_TYPE = t; CMD_ADDR = a; CMD_DATA0 = d0; CMD_DATA1 = d1; CMD_FUNC = fn;
    BIT_CYCLES = bcy; PAR_EN = pe; PAR_TYP = pt; GAP_BITS = g; CMD_VALID = 1;
    @(posedge CLK);
    #1 CMD_VALID = 0;
  endtask

  task automatic test_reset;
    RST = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    tests += 5;
    if (SER_OUT !== 1'b1) begin fails++; $display("FAIL reset_ser got %b exp 1", SER_OUT); end
    if (CMD_READY !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", CMD_READY); end
    if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    if (FRAME_DONE !== 1'b0) begin fails++; $display("FAIL reset_fd got %b exp 0", FRAME_DONE); end
    if (CMD_DONE !== 1'b0) begin fails++; $display("FAIL reset_cd got %b exp 0", CMD_DONE); end
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_rf_write;
    build(3, {8'h00, 8'h3C, 8'h05, 8'hAA}, 1, 4'b0000, 8, 1);
    issue(0, 4'h5, 8'h3C, 8'h00, 4'h0, 16'd8, 1, 0, 4'd1);
    bs = 0; bf = 0; bc = 0; bb = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL wr_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if (FRAME_DONE !== exp_fd[i] && !bf) begin bf = 1; fails++; $display("FAIL wr_fd cyc %0d got %b exp %b", i, FRAME_DONE, exp_fd[i]); end
      if (CMD_DONE !== (i == exp_len - 1) && !bc) begin bc = 1; fails++; $display("FAIL wr_cd cyc %0d got %b exp %b", i, CMD_DONE, i == exp_len - 1); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL wr_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
    end
    tests += 5;
    @(negedge CLK);
    if ({BUSY, CMD_READY, SER_OUT} !== 3'b011) begin fails++; $display("FAIL wr_end got %b exp 011", {BUSY, CMD_READY, SER_OUT}); end
  endtask

  task automatic test_rf_read_odd;
    build(2, {16'h0000, 8'h0E, 8'hBB}, 1, 4'b0001, 4, 0);
    issue(1, 4'hE, 8'h00, 8'h00, 4'h0, 16'd4, 1, 1, 4'd0);
    bs = 0; bf = 0; bc = 0; bb = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL rd_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if (FRAME_DONE !== exp_fd[i] && !bf) begin bf = 1; fails++; $display("FAIL rd_fd cyc %0d got %b exp %b", i, FRAME_DONE, exp_fd[i]); end
      if (CMD_DONE !== (i == exp_len - 1) && !bc) begin bc = 1; fails++; $display("FAIL rd_cd cyc %0d got %b exp %b", i, CMD_DONE, i == exp_len - 1); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL rd_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
    end
    tests += 5;
    @(negedge CLK);
    if ({BUSY, CMD_READY, SER_OUT} !== 3'b011) begin fails++; $display("FAIL rd_end got %b exp 011", {BUSY, CMD_READY, SER_OUT}); end
  endtask

  task automatic test_alu_noop_b0;
    build(2, {16'h0000, 8'h03, 8'hDD}, 0, 4'b0000, 1, 2);
    issue(3, 4'h0, 8'h00, 8'h00, 4'h3, 16'd0, 0, 0, 4'd2);
    bs = 0; bf = 0; bc = 0; bb = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL b0_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if (FRAME_DONE !== exp_fd[i] && !bf) begin bf = 1; fails++; $display("FAIL b0_fd cyc %0d got %b exp %b", i, FRAME_DONE, exp_fd[i]); end
      if (CMD_DONE !== (i == exp_len - 1) && !bc) begin bc = 1; fails++; $display("FAIL b0_cd cyc %0d got %b exp %b", i, CMD_DONE, i == exp_len - 1); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL b0_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
    end
    tests += 5;
    @(negedge CLK);
    if ({BUSY, CMD_READY, SER_OUT} !== 3'b011) begin fails++; $display("FAIL b0_end got %b exp 011", {BUSY, CMD_READY, SER_OUT}); end
  endtask

  task automatic test_alu_op_stable;
    build(4, {8'h01, 8'h34, 8'h12, 8'hCC}, 0, 4'b0000, 16, 1);
    issue(2, 4'h0, 8'h12, 8'h34, 4'h1, 16'd16, 0, 0, 4'd1);
    bs = 0; bf = 0; bc = 0; bb = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL alu_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if (FRAME_DONE !== exp_fd[i] && !bf) begin bf = 1; fails++; $display("FAIL alu_fd cyc %0d got %b exp %b", i, FRAME_DONE, exp_fd[i]); end
      if (CMD_DONE !== (i == exp_len - 1) && !bc) begin bc = 1; fails++; $display("FAIL alu_cd cyc %0d got %b exp %b", i, CMD_DONE, i == exp_len - 1); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL alu_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
      CMD_VALID = (i % 3) == 0;
      CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_DATA0 = 8'($urandom); CMD_DATA1 = 8'($urandom);
      CMD_FUNC = 4'($urandom); BIT_CYCLES = 16'($urandom_range(1, 5)); PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom); GAP_BITS = 4'($urandom);
    end
    CMD_VALID = 0;
    tests += 5;
    @(negedge CLK);
    if ({BUSY, CMD_READY, SER_OUT} !== 3'b011) begin fails++; $display("FAIL alu_end got %b exp 011", {BUSY, CMD_READY, SER_OUT}); end
  endtask

  task automatic test_reset_abort;
    build(3, {8'h00, 8'h5A, 8'h07, 8'hAA}, 0, 4'b0000, 2, 0);
    issue(0, 4'h7, 8'h5A, 8'h00, 4'h0, 16'd2, 0, 0, 4'd0);
    bs = 0; bb = 0;
    for (int i = 0; i < 49; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL ab_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL ab_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
    end
    tests += 2;
    RST = 1;
    @(negedge CLK);
    tests++;
    if ({SER_OUT, BUSY, CMD_READY, FRAME_DONE, CMD_DONE} !== 5'b10100) begin
      fails++; $display("FAIL ab_rst got %b exp 10100", {SER_OUT, BUSY, CMD_READY, FRAME_DONE, CMD_DONE});
    end
    repeat (2) @(negedge CLK);
    RST = 0;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if ({SER_OUT, CMD_DONE, FRAME_DONE} !== 3'b100 && !bc) begin bc = 1; fails++; $display("FAIL ab_idle cyc %0d got %b exp 100", i, {SER_OUT, CMD_DONE, FRAME_DONE}); end
    end
    tests++;
    build(2, {16'h0000, 8'h03, 8'hBB}, 0, 4'b0000, 1, 0);
    issue(1, 4'h3, 8'h00, 8'h00, 4'h0, 16'd1, 0, 0, 4'd0);
    bs = 0; bf = 0; bc = 0; bb = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL ab2_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if (FRAME_DONE !== exp_fd[i] && !bf) begin bf = 1; fails++; $display("FAIL ab2_fd cyc %0d got %b exp %b", i, FRAME_DONE, exp_fd[i]); end
      if (CMD_DONE !== (i == exp_len - 1) && !bc) begin bc = 1; fails++; $display("FAIL ab2_cd cyc %0d got %b exp %b", i, CMD_DONE, i == exp_len - 1); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL ab2_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
    end
    tests += 5;
    @(negedge CLK);
    if ({BUSY, CMD_READY, SER_OUT} !== 3'b011) begin fails++; $display("FAIL ab2_end got %b exp 011", {BUSY, CMD_READY, SER_OUT}); end
  endtask

  task automatic test_back_to_back;
    build(2, {16'h0000, 8'h01, 8'hBB}, 0, 4'b0000, 2, 0);
    issue(1, 4'h1, 8'h00, 8'h00, 4'h0, 16'd2, 0, 0, 4'd0);
    bs = 0; bf = 0; bc = 0; bb = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL bb1_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if (FRAME_DONE !== exp_fd[i] && !bf) begin bf = 1; fails++; $display("FAIL bb1_fd cyc %0d got %b exp %b", i, FRAME_DONE, exp_fd[i]); end
      if (CMD_DONE !== (i == exp_len - 1) && !bc) begin bc = 1; fails++; $display("FAIL bb1_cd cyc %0d got %b exp %b", i, CMD_DONE, i == exp_len - 1); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL bb1_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
    end
    tests += 5;
    build(2, {16'h0000, 8'h02, 8'hBB}, 1, 4'b0010, 2, 0);
    @(negedge CLK);
    if ({BUSY, CMD_READY, SER_OUT} !== 3'b011) begin fails++; $display("FAIL bb_ready got %b exp 011", {BUSY, CMD_READY, SER_OUT}); end
    issue(1, 4'h2, 8'h00, 8'h00, 4'h0, 16'd2, 1, 0, 4'd0);
    bs = 0; bf = 0; bc = 0; bb = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge CLK);
      if (SER_OUT !== exp_ser[i] && !bs) begin bs = 1; fails++; $display("FAIL bb2_ser cyc %0d got %b exp %b", i, SER_OUT, exp_ser[i]); end
      if (FRAME_DONE !== exp_fd[i] && !bf) begin bf = 1; fails++; $display("FAIL bb2_fd cyc %0d got %b exp %b", i, FRAME_DONE, exp_fd[i]); end
      if (CMD_DONE !== (i == exp_len - 1) && !bc) begin bc = 1; fails++; $display("FAIL bb2_cd cyc %0d got %b exp %b", i, CMD_DONE, i == exp_len - 1); end
      if ({BUSY, CMD_READY} !== 2'b10 && !bb) begin bb = 1; fails++; $display("FAIL bb2_busy cyc %0d got %b exp 10", i, {BUSY, CMD_READY}); end
    end
    tests += 5;
    @(negedge CLK);
    if ({BUSY, CMD_READY, SER_OUT} !== 3'b011) begin fails++; $display("FAIL bb2_end got %b exp 011", {BUSY, CMD_READY, SER_OUT}); end
  endtask

  initial begin
    test_reset;
    test_rf_write;
    test_rf_read_odd;
    test_alu_noop_b0;
    test_alu_op_stable;
    test_reset_abort;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
